mc_ctrl: RTL

- Multi-cycle control FSM for the MIPS CPU.
- Sequences fetch, decode, execute, memory and writeback for the supported instruction subset.
- Drives EXTOp to the immediate extender, plus ALU, register-file, NPC and memory controls.
- Handles a req/ready memory handshake with an optional wait timeout.

---
 rtl/mc_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with a req/ready memory handshake and an optional bounded wait.
module mc_ctrl #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] EXTOp,
  output logic       ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [2:0] state_o,
  output logic       illegal_o,
  output logic       mem_timeout_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI  = 4'd10;

  state_t     state_reg, state_next;
  logic       r_alu, shift, i_alu, load, store, beq, bne, jmp, jal;
  logic       legal, src_imm, take;
  logic [3:0] alu_dec;
  logic [1:0] ext_dec;
  logic       in_req, timeout_hit;

  always_comb begin
    r_alu = 1'b0; shift = 1'b0; i_alu = 1'b0; load = 1'b0; store = 1'b0;
    beq = 1'b0; bne = 1'b0; jmp = 1'b0; jal = 1'b0;
    alu_dec = ALU_ADD;
    ext_dec = 2'd0;
    case (op_i)
      6'h00: begin
        case (funct_i)
          6'h20: r_alu = 1'b1;
          6'h22: begin r_alu = 1'b1; alu_dec = ALU_SUB; end
          6'h24: begin r_alu = 1'b1; alu_dec = ALU_AND; end
          6'h25: begin r_alu = 1'b1; alu_dec = ALU_OR;  end
          6'h2A: begin r_alu = 1'b1; alu_dec = ALU_SLT; end
          6'h00: begin shift = 1'b1; alu_dec = ALU_SLL; ext_dec = 2'd2; end
          6'h02: begin shift = 1'b1; alu_dec = ALU_SRL; ext_dec = 2'd2; end
          6'h03: begin shift = 1'b1; alu_dec = ALU_SRA; ext_dec = 2'd2; end
          default: ;
        endcase
      end
      6'h08: begin i_alu = 1'b1; ext_dec = 2'd1; end
      6'h09: i_alu = 1'b1;
      6'h0C: begin i_alu = 1'b1; alu_dec = ALU_AND;  end
      6'h0D: begin i_alu = 1'b1; alu_dec = ALU_OR;   end
      6'h0E: begin i_alu = 1'b1; alu_dec = ALU_XOR;  end
      6'h0F: begin i_alu = 1'b1; alu_dec = ALU_LUI;  end
      6'h0A: begin i_alu = 1'b1; alu_dec = ALU_SLT;  ext_dec = 2'd1; end
      6'h0B: begin i_alu = 1'b1; alu_dec = ALU_SLTU; end
      6'h23: begin load = 1'b1; ext_dec = 2'd1; end
      6'h20: load = 1'b1;
      6'h24: load = 1'b1;
      6'h2B: begin store = 1'b1; ext_dec = 2'd1; end
      6'h04: begin beq = 1'b1; alu_dec = ALU_SUB; ext_dec = 2'd1; end
      6'h05: begin bne = 1'b1; alu_dec = ALU_SUB; ext_dec = 2'd1; end
      6'h02: jmp = 1'b1;
      6'h03: jal = 1'b1;
      default: ;
    endcase
  end

  assign legal   = r_alu | shift | i_alu | load | store | beq | bne | jmp | jal;
  assign src_imm = i_alu | load | store | shift;
  assign take    = (beq & zero_i) | (bne & ~zero_i);
  assign in_req  = (state_reg == S_FETCH) || (state_reg == S_MEM);

  generate
    if (WAIT_LIMIT > 0) begin : g_wait
      localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
      logic [CW-1:0] wait_cnt_reg;

      // Ready in the last allowed cycle wins over the timeout.
      assign timeout_hit = in_req && !mem_ready_i && (wait_cnt_reg == CW'(WAIT_LIMIT - 1));

      always_ff @(posedge clk) begin
        if (rst)
          wait_cnt_reg <= '0;
        else if (in_req && !mem_ready_i && !timeout_hit)
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
        else
          wait_cnt_reg <= '0;
      end
    end else begin : g_nowait
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= S_FETCH;
    else
      state_reg <= state_next;
  end

  assign state_o = rst ? 3'd0 : state_reg;

  // Outputs forced low during reset so an abandoned instruction writes nothing.
  always_comb begin
    state_next    = state_reg;
    mem_req_o     = 1'b0;
    MemWrite      = 1'b0;
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    EXTOp         = 2'd0;
    ALUSrcB       = 1'b0;
    ALUOp         = ALU_ADD;
    RegDst        = 2'd0;
    WDSel         = 2'd0;
    NPCOp         = 2'd0;
    illegal_o     = 1'b0;
    mem_timeout_o = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            state_next = S_DECODE;
          end else if (timeout_hit) begin
            mem_timeout_o = 1'b1;
            state_next    = S_FETCH;
          end
        end
        S_DECODE: begin
          EXTOp = ext_dec;
          if (jmp || jal) begin
            PCWrite    = 1'b1;
            NPCOp      = 2'd2;
            state_next = S_FETCH;
            if (jal) begin
              RegWrite = 1'b1;
              RegDst   = 2'd2;
              WDSel    = 2'd2;
            end
          end else if (!legal) begin
            illegal_o  = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_EXE;
          end
        end
        S_EXE: begin
          EXTOp   = ext_dec;
          ALUOp   = alu_dec;
          ALUSrcB = src_imm;
          if (beq || bne) begin
            PCWrite    = take;
            NPCOp      = take ? 2'd1 : 2'd0;
            state_next = S_FETCH;
          end else if (load || store) begin
            state_next = S_MEM;
          end else begin
            state_next = S_WB;
          end
        end
        S_MEM: begin
          EXTOp     = ext_dec;
          mem_req_o = 1'b1;
          MemWrite  = store && !timeout_hit;
          if (mem_ready_i)
            state_next = store ? S_FETCH : S_WB;
          else if (timeout_hit) begin
            mem_timeout_o = 1'b1;
            state_next    = S_FETCH;
          end
        end
        S_WB: begin
          EXTOp      = ext_dec;
          RegWrite   = 1'b1;
          RegDst     = (op_i == 6'h00) ? 2'd1 : 2'd0;
          WDSel      = load ? 2'd1 : 2'd0;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule
